// File: rtl/afisare_multiplexata_n.sv
// Time-multiplexed driver for an N-digit 7-segment display.
//
// Scans one digit per slot of PRESCALE clocks. The first BLANK_CYCLES of every slot
// keep all digits off to avoid ghosting. Displayed content is captured once per
// frame, so a frame never mixes old and new content. Turn markers and dashes can
// blink with a half-period of BLINK_FRAMES frames.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   semnal_stanga  left turn indication
//   semnal_dreapta right turn indication
//   stop           stop condition (highest priority)
//   cifra_zeci     tens BCD digit
//   cifra_unitati  units BCD digit
//   blink_en       enable blinking of markers/dashes in turn modes
//   digit_sel      one-hot digit enable, bit 0 = leftmost digit
//   seg            segments {a,b,c,d,e,f,g}
//   frame_tick     one-cycle pulse at each frame boundary
module afisare_multiplexata_n #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned PRESCALE        = 1024,
  parameter int unsigned BLANK_CYCLES    = 16,
  parameter int unsigned BLINK_FRAMES    = 128,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1,
  parameter bit          DIG_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  semnal_stanga,
  input  logic                  semnal_dreapta,
  input  logic                  stop,
  input  logic [3:0]            cifra_zeci,
  input  logic [3:0]            cifra_unitati,
  input  logic                  blink_en,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [6:0]            seg,
  output logic                  frame_tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SlotLast  = SW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);

  localparam logic [6:0]            SegBlank = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DigOff   = DIG_ACTIVE_HIGH ? '0 : '1;

  localparam logic [3:0] CodeAll   = 4'd8;
  localparam logic [3:0] CodeRight = 4'd10;
  localparam logic [3:0] CodeLeft  = 4'd11;
  localparam logic [3:0] CodeDash  = 4'd12;
  localparam logic [3:0] CodeBlank = 4'd13;

  // Segments lit (active-high) for a glyph code, {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph_lit(input logic [3:0] code);
    logic [6:0] lit;
    case (code)
      4'd0:    lit = 7'b1111110;
      4'd1:    lit = 7'b0110000;
      4'd2:    lit = 7'b1101101;
      4'd3:    lit = 7'b1111001;
      4'd4:    lit = 7'b0110011;
      4'd5:    lit = 7'b1011011;
      4'd6:    lit = 7'b1011111;
      4'd7:    lit = 7'b1110000;
      4'd8:    lit = 7'b1111111;
      4'd9:    lit = 7'b1111011;
      4'd10:   lit = 7'b1111001;
      4'd11:   lit = 7'b1001111;
      4'd12:   lit = 7'b0000001;
      default: lit = 7'b0000000;
    endcase
    return lit;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  phase_on_q, phase_on_d;
  logic [3:0]            content_q [NUM_DIGITS];
  logic [3:0]            content_d [NUM_DIGITS];
  logic                  blink_flag_q, blink_flag_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_end;

  // Scan counters.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    slot_d    = slot_q;
    frame_end = 1'b0;
    if (presc_q == PrescLast) begin
      presc_d = '0;
      if (slot_q == SlotLast) begin
        slot_d    = '0;
        frame_end = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Blink phase advances once per frame.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    if (frame_end) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Content snapshot, taken only on the frame boundary.
  always_comb begin
    logic [3:0] tens_code, units_code;
    tens_code    = (cifra_zeci > 4'd9) ? CodeDash : cifra_zeci;
    units_code   = (cifra_unitati > 4'd9) ? CodeDash : cifra_unitati;
    content_d    = content_q;
    blink_flag_d = blink_flag_q;
    if (frame_end) begin
      blink_flag_d = blink_en & ~stop & (semnal_stanga | semnal_dreapta);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (stop) begin
          content_d[i] = CodeAll;
        end else if (semnal_stanga && semnal_dreapta) begin
          content_d[i] = CodeDash;
        end else if (semnal_stanga) begin
          content_d[i] = (i == 0) ? CodeLeft : CodeDash;
        end else if (semnal_dreapta) begin
          content_d[i] = (i == NUM_DIGITS - 1) ? CodeRight : CodeDash;
        end else if (i == NUM_DIGITS / 2 - 1) begin
          content_d[i] = tens_code;
        end else if (i == NUM_DIGITS / 2) begin
          content_d[i] = units_code;
        end else begin
          content_d[i] = CodeBlank;
        end
      end
    end
  end

  // Output stage: decoded from the current scan state, registered one cycle later.
  always_comb begin
    logic [3:0]            code;
    logic [6:0]            lit;
    logic [NUM_DIGITS-1:0] onehot;
    code = content_q[slot_q];
    if (blink_flag_q && !phase_on_q) begin
      code = CodeBlank;
    end
    lit    = glyph_lit(code);
    onehot = '0;
    onehot[slot_q] = 1'b1;
    if (32'(presc_q) < BLANK_CYCLES) begin
      dig_d = DigOff;
      seg_d = SegBlank;
    end else begin
      dig_d = DIG_ACTIVE_HIGH ? onehot : ~onehot;
      seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      slot_q       <= '0;
      blink_cnt_q  <= '0;
      phase_on_q   <= 1'b1;
      blink_flag_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        content_q[i] <= CodeBlank;
      end
      dig_q        <= DigOff;
      seg_q        <= SegBlank;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_on_q   <= phase_on_d;
      blink_flag_q <= blink_flag_d;
      content_q    <= content_d;
      dig_q        <= dig_d;
      seg_q        <= seg_d;
    end
  end

  assign digit_sel  = dig_q;
  assign seg        = seg_q;
  assign frame_tick = frame_end;

endmodule

// File: tb/tb_afisare_multiplexata_n.sv
module tb_afisare_multiplexata_n;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       semnal_stanga = 1'b0;
  logic       semnal_dreapta = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] cifra_zeci = 4'd0;
  logic [3:0] cifra_unitati = 4'd0;
  logic       blink_en = 1'b0;
  logic [3:0] digit_sel;
  logic [6:0] seg;
  logic       frame_tick;

  int n_checks = 0;
  int n_pass = 0;

  // Frame capture, index j = 1..32 counts negedges after a frame boundary.
  logic [3:0] obs_dig  [1:32];
  logic [6:0] obs_seg  [1:32];
  logic       obs_tick [1:32];

  // Active-low segment patterns for digits 0..9.
  logic [6:0] gl [0:9];
  localparam logic [6:0] SBlank = 7'b1111111;
  localparam logic [6:0] SDash  = 7'b1111110;
  localparam logic [6:0] SRight = 7'b0000110;
  localparam logic [6:0] SLeft  = 7'b0110000;
  localparam logic [6:0] SAll   = 7'b0000000;

  always #5 clock = ~clock;

  afisare_multiplexata_n #(
    .NUM_DIGITS     (4),
    .PRESCALE       (8),
    .BLANK_CYCLES   (2),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_HIGH(1'b1)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .semnal_stanga (semnal_stanga),
    .semnal_dreapta(semnal_dreapta),
    .stop          (stop),
    .cifra_zeci    (cifra_zeci),
    .cifra_unitati (cifra_unitati),
    .blink_en      (blink_en),
    .digit_sel     (digit_sel),
    .seg           (seg),
    .frame_tick    (frame_tick)
  );

  task automatic capture_frame();
    for (int j = 1; j <= 32; j++) begin
      @(negedge clock);
      obs_dig[j]  = digit_sel;
      obs_seg[j]  = seg;
      obs_tick[j] = frame_tick;
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (frame_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] ed;
    cifra_zeci = 4'd4;
    cifra_unitati = 4'd2;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (digit_sel !== 4'b0000) $display("FAIL reset_digit_sel: got %b want 0000", digit_sel);
    else n_pass++;
    n_checks++;
    if (seg !== SBlank) $display("FAIL reset_seg: got %b want %b", seg, SBlank);
    else n_pass++;
    n_checks++;
    if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick);
    else n_pass++;
    release_reset();
    capture_frame();
    // Frame 0 shows reset content (blank); blank window is 2 cycles per slot.
    for (int j = 1; j <= 32; j++) begin
      int s, r;
      s = (j - 2) / 8;
      r = (j - 2) % 8;
      ed = (j == 1 || r < 2) ? 4'b0000 : (4'b0001 << s);
      n_checks++;
      if (obs_dig[j] !== ed) $display("FAIL frame0_dig[%0d]: got %b want %b", j, obs_dig[j], ed);
      else n_pass++;
      n_checks++;
      if (obs_seg[j] !== SBlank)
        $display("FAIL frame0_seg[%0d]: got %b want %b", j, obs_seg[j], SBlank);
      else n_pass++;
      n_checks++;
      if (obs_tick[j] !== (j == 32))
        $display("FAIL frame0_tick[%0d]: got %b want %b", j, obs_tick[j], (j == 32));
      else n_pass++;
    end
  endtask

  task automatic test_normal();
    logic [3:0] ed;
    logic [6:0] es;
    logic [6:0] row [0:3];
    row[0] = SBlank; row[1] = gl[4]; row[2] = gl[2]; row[3] = SBlank;
    capture_frame();
    for (int j = 2; j <= 32; j++) begin
      int s, r;
      s = (j - 2) / 8;
      r = (j - 2) % 8;
      ed = (r < 2) ? 4'b0000 : (4'b0001 << s);
      es = (r < 2) ? SBlank : row[s];
      n_checks++;
      if (obs_dig[j] !== ed) $display("FAIL normal_dig[%0d]: got %b want %b", j, obs_dig[j], ed);
      else n_pass++;
      n_checks++;
      if (obs_seg[j] !== es) $display("FAIL normal_seg[%0d]: got %b want %b", j, obs_seg[j], es);
      else n_pass++;
      n_checks++;
      if (obs_tick[j] !== (j == 32))
        $display("FAIL normal_tick[%0d]: got %b want %b", j, obs_tick[j], (j == 32));
      else n_pass++;
    end
  endtask

  task automatic test_stop();
    bit ok;
    stop = 1'b1;
    semnal_stanga = 1'b1;
    blink_en = 1'b1;
    wait_tick(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL stop_tick_timeout: got %b want 1", ok);
    else n_pass++;
    // Three frames cover at least one blink-off phase; stop never blinks.
    for (int f = 0; f < 3; f++) begin
      capture_frame();
      for (int s = 0; s < 4; s++) begin
        n_checks++;
        if (obs_seg[8*s+5] !== SAll || obs_dig[8*s+5] !== (4'b0001 << s))
          $display("FAIL stop_digit%0d: got seg %b dig %b want seg %b", s, obs_seg[8*s+5],
                   obs_dig[8*s+5], SAll);
        else n_pass++;
      end
    end
    stop = 1'b0;
    semnal_stanga = 1'b0;
  endtask

  task automatic test_blink();
    logic [6:0] es;
    bit on;
    semnal_dreapta = 1'b1;
    blink_en = 1'b1;
    reset_n = 1'b0;
    release_reset();
    capture_frame();
    for (int k = 1; k <= 6; k++) begin
      capture_frame();
      on = ((k / 2) % 2) == 0;
      for (int s = 0; s < 4; s++) begin
        es = !on ? SBlank : (s == 3) ? SRight : SDash;
        n_checks++;
        if (obs_seg[8*s+5] !== es)
          $display("FAIL blink_f%0d_d%0d: got %b want %b", k, s, obs_seg[8*s+5], es);
        else n_pass++;
      end
    end
    semnal_dreapta = 1'b0;
    blink_en = 1'b0;
  endtask

  task automatic test_dash();
    bit ok;
    logic [6:0] es;
    for (int m = 0; m < 3; m++) begin
      semnal_stanga  = (m != 2);
      semnal_dreapta = (m == 0);
      cifra_zeci     = 4'hB;
      cifra_unitati  = 4'hF;
      wait_tick(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL dash_tick_timeout: got %b want 1", ok);
      else n_pass++;
      capture_frame();
      for (int s = 0; s < 4; s++) begin
        if (m == 0) es = SDash;
        else if (m == 1) es = (s == 0) ? SLeft : SDash;
        else es = (s == 1 || s == 2) ? SDash : SBlank;
        n_checks++;
        if (obs_seg[8*s+5] !== es)
          $display("FAIL dash_m%0d_d%0d: got %b want %b", m, s, obs_seg[8*s+5], es);
        else n_pass++;
      end
    end
    semnal_stanga = 1'b0;
    semnal_dreapta = 1'b0;
  endtask

  task automatic test_glyphs();
    bit ok;
    blink_en = 1'b1;
    for (int v = 0; v < 10; v++) begin
      cifra_zeci    = 4'(v);
      cifra_unitati = 4'(9 - v);
      wait_tick(ok);
      capture_frame();
      n_checks++;
      if (!ok || obs_seg[13] !== gl[v])
        $display("FAIL glyph_tens%0d: got %b want %b (tick %b)", v, obs_seg[13], gl[v], ok);
      else n_pass++;
      n_checks++;
      if (obs_seg[21] !== gl[9-v])
        $display("FAIL glyph_units%0d: got %b want %b", 9 - v, obs_seg[21], gl[9-v]);
      else n_pass++;
    end
    blink_en = 1'b0;
  endtask

  task automatic test_no_tearing();
    bit ok;
    cifra_zeci = 4'd5;
    cifra_unitati = 4'd6;
    wait_tick(ok);
    wait_tick(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL tear_tick_timeout: got %b want 1", ok);
    else n_pass++;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clock);
      if (j == 18) semnal_stanga = 1'b1;
      if (j == 21) begin
        n_checks++;
        if (seg !== gl[6] || digit_sel !== 4'b0100)
          $display("FAIL tear_slot2: got seg %b dig %b want seg %b dig 0100", seg, digit_sel, gl[6]);
        else n_pass++;
      end
      if (j == 29) begin
        n_checks++;
        if (seg !== SBlank || digit_sel !== 4'b1000)
          $display("FAIL tear_slot3: got seg %b dig %b want seg %b dig 1000", seg, digit_sel, SBlank);
        else n_pass++;
      end
      if (j == 32) begin
        n_checks++;
        if (frame_tick !== 1'b1) $display("FAIL tear_tick: got %b want 1", frame_tick);
        else n_pass++;
      end
    end
    capture_frame();
    n_checks++;
    if (obs_seg[5] !== SLeft) $display("FAIL tear_next_d0: got %b want %b", obs_seg[5], SLeft);
    else n_pass++;
    n_checks++;
    if (obs_seg[21] !== SDash) $display("FAIL tear_next_d2: got %b want %b", obs_seg[21], SDash);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_tick(ok);
    repeat (5) @(negedge clock);
    n_checks++;
    if (digit_sel !== 4'b0001) $display("FAIL midrst_pre: got %b want 0001", digit_sel);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (digit_sel !== 4'b0000 || seg !== SBlank)
      $display("FAIL midrst_async: got dig %b seg %b want 0000 %b", digit_sel, seg, SBlank);
    else n_pass++;
    release_reset();
    capture_frame();
    n_checks++;
    if (obs_dig[5] !== 4'b0001 || obs_dig[13] !== 4'b0010)
      $display("FAIL midrst_restart: got %b %b want 0001 0010", obs_dig[5], obs_dig[13]);
    else n_pass++;
    n_checks++;
    if (obs_seg[5] !== SBlank) $display("FAIL midrst_content: got %b want %b", obs_seg[5], SBlank);
    else n_pass++;
    n_checks++;
    if (obs_tick[32] !== 1'b1 || obs_tick[16] !== 1'b0)
      $display("FAIL midrst_tick: got %b%b want 10", obs_tick[32], obs_tick[16]);
    else n_pass++;
    semnal_stanga = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    bit started;
    int run;
    logic [3:0] prev;
    started = 1'b0;
    run = 0;
    prev = 4'b0000;
    wait_tick(ok);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      n_checks++;
      if ($countones(digit_sel) > 1) $display("FAIL rand_onehot[%0d]: got %b want <=1 hot", i, digit_sel);
      else n_pass++;
      if (digit_sel != 4'b0000) begin
        run = (digit_sel == prev) ? run + 1 : 1;
      end else if (prev != 4'b0000) begin
        if (started) begin
          n_checks++;
          if (run != 6) $display("FAIL rand_active_len[%0d]: got %0d want 6", i, run);
          else n_pass++;
        end
        started = 1'b1;
      end
      prev = digit_sel;
      stop           = ($urandom_range(0, 7) == 0);
      semnal_stanga  = 1'($urandom_range(0, 1));
      semnal_dreapta = 1'($urandom_range(0, 1));
      blink_en       = 1'($urandom_range(0, 1));
      cifra_zeci     = 4'($urandom_range(0, 15));
      cifra_unitati  = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    gl[0] = 7'b0000001; gl[1] = 7'b1001111; gl[2] = 7'b0010010; gl[3] = 7'b0000110;
    gl[4] = 7'b1001100; gl[5] = 7'b0100100; gl[6] = 7'b0100000; gl[7] = 7'b0001111;
    gl[8] = 7'b0000000; gl[9] = 7'b0000100;
    test_reset();
    test_normal();
    test_stop();
    test_blink();
    test_dash();
    test_glyphs();
    test_no_tearing();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
